// File: rtl/alu_sequencer.sv
// alu_sequencer
// Multi-cycle Moore controller for the simple datapath.  It accepts one
// 16-bit instruction per s/w handshake, decodes it, and then walks through
// register reads, the ALU operation, status load and register write-back,
// driving the register-file, pipeline-register and ALU controls.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   s         start request, sampled only while idle in WAIT
//   in        16-bit instruction, latched on an accepted start
//   w         1 = idle in WAIT and ready for s
//   readnum   register-file read address
//   writenum  register-file write address
//   write     register-file write enable
//   loada     load A pipeline register
//   loadb     load B pipeline register
//   loadc     load C result register
//   loads     load status (Z) register
//   asel      1 = ALU A input forced to 0
//   bsel      1 = ALU B input from sximm8 (always 0 in this instruction subset)
//   vsel      write-back source: 00 = C, 10 = sximm8
//   ALUop     ALU operation: 00 ADD, 01 SUB/CMP, 10 AND, 11 NOT B
//   shift     shifter control for the B path
//   sximm8    sign-extended imm8 of the latched instruction
//   illegal   one-cycle pulse on an undecodable instruction
//
// Handshake: w is high exactly while the controller sits in WAIT.  A start
// is accepted on a rising edge where w=1 and s=1; `in` is captured on that
// same edge.  s and `in` are ignored in every other state, so s may be held
// high and will be re-accepted in the first WAIT cycle after completion.
//
// The current FSM state is kept in the signal `state` for inspection.

module alu_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s,
   input  logic [15:0]      in,
   output logic             w,
   output logic [2:0]       readnum,
   output logic [2:0]       writenum,
   output logic             write,
   output logic             loada,
   output logic             loadb,
   output logic             loadc,
   output logic             loads,
   output logic             asel,
   output logic             bsel,
   output logic [1:0]       vsel,
   output logic [1:0]       ALUop,
   output logic [1:0]       shift,
   output logic [WIDTH-1:0] sximm8,
   output logic             illegal
);

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_ILLEGAL   = 3'd2,
      S_WRITE_IMM = 3'd3,
      S_GET_A     = 3'd4,
      S_GET_B     = 3'd5,
      S_EXEC      = 3'd6,
      S_WRITE_REG = 3'd7
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] instr;

   // Latched instruction fields
   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] rn;
   logic [2:0] rd;
   logic [1:0] sh;
   logic [2:0] rm;
   logic [7:0] imm8;

   assign opcode = instr[15:13];
   assign op     = instr[12:11];
   assign rn     = instr[10:8];
   assign rd     = instr[7:5];
   assign sh     = instr[4:3];
   assign rm     = instr[2:0];
   assign imm8   = instr[7:0];

   // Instruction classes
   logic is_mov_imm;
   logic is_mov_reg;
   logic is_alu;
   logic is_cmp;
   logic is_mvn;

   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu     = (opcode == 3'b101);
   assign is_cmp     = is_alu && (op == 2'b01);
   assign is_mvn     = is_alu && (op == 2'b11);

   // Held constant from the accepting edge until the next accepted start.
   assign sximm8 = {{(WIDTH-8){imm8[7]}}, imm8};

   // State register and instruction latch
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_WAIT;
         instr <= 16'h0000;
      end else begin
         state <= state_next;
         if (state == S_WAIT && s) begin
            instr <= in;
         end
      end
   end

   // Next-state and Moore output decode
   always_comb begin
      state_next = state;
      w          = 1'b0;
      readnum    = 3'd0;
      writenum   = 3'd0;
      write      = 1'b0;
      loada      = 1'b0;
      loadb      = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      asel       = 1'b0;
      bsel       = 1'b0;
      vsel       = 2'b00;
      ALUop      = 2'b00;
      shift      = 2'b00;
      illegal    = 1'b0;

      case (state)
         S_WAIT: begin
            w = 1'b1;
            if (s) begin
               state_next = S_DECODE;
            end
         end

         S_DECODE: begin
            if (is_mov_imm) begin
               state_next = S_WRITE_IMM;
            end else if (is_mov_reg || is_mvn) begin
               // Single-operand forms only need the B operand.
               state_next = S_GET_B;
            end else if (is_alu) begin
               state_next = S_GET_A;
            end else begin
               state_next = S_ILLEGAL;
            end
         end

         S_ILLEGAL: begin
            illegal    = 1'b1;
            state_next = S_WAIT;
         end

         S_WRITE_IMM: begin
            vsel       = 2'b10;
            writenum   = rn;
            write      = 1'b1;
            state_next = S_WAIT;
         end

         S_GET_A: begin
            readnum    = rn;
            loada      = 1'b1;
            state_next = S_GET_B;
         end

         S_GET_B: begin
            readnum    = rm;
            loadb      = 1'b1;
            state_next = S_EXEC;
         end

         S_EXEC: begin
            shift = sh;
            if (is_mov_reg) begin
               // MOV reg computes 0 + shifted B.
               ALUop = 2'b00;
               asel  = 1'b1;
               loadc = 1'b1;
            end else if (is_cmp) begin
               // CMP only updates status; nothing is written back.
               ALUop = 2'b01;
               loads = 1'b1;
            end else begin
               ALUop = op;
               loadc = 1'b1;
            end
            state_next = is_cmp ? S_WAIT : S_WRITE_REG;
         end

         S_WRITE_REG: begin
            vsel       = 2'b00;
            writenum   = rd;
            write      = 1'b1;
            state_next = S_WAIT;
         end

         default: begin
            state_next = S_WAIT;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed instructions from the test plan,
// a mid-sequence reset, then randomized instruction streams with random
// idle gaps and back-to-back starts.  Expected per-cycle control vectors
// come from a micro-op list built from the instruction class rules.

module tb_alu_sequencer;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             s;
   logic [15:0]      in;
   logic             w;
   logic [2:0]       readnum;
   logic [2:0]       writenum;
   logic             write;
   logic             loada;
   logic             loadb;
   logic             loadc;
   logic             loads;
   logic             asel;
   logic             bsel;
   logic [1:0]       vsel;
   logic [1:0]       aluop;
   logic [1:0]       shift;
   logic [WIDTH-1:0] sximm8;
   logic             illegal;

   alu_sequencer #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .s        (s),
      .in       (in),
      .w        (w),
      .readnum  (readnum),
      .writenum (writenum),
      .write    (write),
      .loada    (loada),
      .loadb    (loadb),
      .loadc    (loadc),
      .loads    (loads),
      .asel     (asel),
      .bsel     (bsel),
      .vsel     (vsel),
      .ALUop    (aluop),
      .shift    (shift),
      .sximm8   (sximm8),
      .illegal  (illegal)
   );

   // Clock / reset block
   always #5 clk = ~clk;

   typedef struct packed {
      logic        w;
      logic [2:0]  readnum;
      logic [2:0]  writenum;
      logic        write;
      logic        loada;
      logic        loadb;
      logic        loadc;
      logic        loads;
      logic        asel;
      logic        bsel;
      logic [1:0]  vsel;
      logic [1:0]  aluop;
      logic [1:0]  shift;
      logic        illegal;
      logic [15:0] sximm8;
   } ctrl_t;

   ctrl_t obs_c;
   assign obs_c = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                   asel, bsel, vsel, aluop, shift, illegal, sximm8};

   // Scoreboard
   logic [36:0] exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] last_instr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model
   function automatic logic [15:0] sext8(input logic [15:0] ins);
      int v;
      v = int'(ins[7:0]);
      if (v >= 128) v = v - 256;
      return 16'(v);
   endfunction

   function automatic ctrl_t base(input logic [15:0] ins);
      ctrl_t c;
      c        = '0;
      c.sximm8 = sext8(ins);
      return c;
   endfunction

   function automatic ctrl_t idle_vec(input logic [15:0] ins);
      ctrl_t c;
      c   = base(ins);
      c.w = 1'b1;
      return c;
   endfunction

   // Push the busy-cycle control sequence an instruction must produce.
   task automatic model(input logic [15:0] ins);
      ctrl_t c;
      logic [2:0] opc;
      logic [1:0] op;
      opc = ins[15:13];
      op  = ins[12:11];
      exp_q.push_back(base(ins));                     // decode cycle
      if (opc == 3'b110 && op == 2'b10) begin         // MOV imm
         c = base(ins); c.vsel = 2'b10; c.writenum = ins[10:8]; c.write = 1'b1;
         exp_q.push_back(c);
      end else if (opc == 3'b110 && op == 2'b00) begin  // MOV reg
         c = base(ins); c.readnum = ins[2:0]; c.loadb = 1'b1;
         exp_q.push_back(c);
         c = base(ins); c.shift = ins[4:3]; c.asel = 1'b1; c.loadc = 1'b1;
         exp_q.push_back(c);
         c = base(ins); c.writenum = ins[7:5]; c.write = 1'b1;
         exp_q.push_back(c);
      end else if (opc == 3'b101) begin               // ADD / CMP / AND / MVN
         if (op != 2'b11) begin
            c = base(ins); c.readnum = ins[10:8]; c.loada = 1'b1;
            exp_q.push_back(c);
         end
         c = base(ins); c.readnum = ins[2:0]; c.loadb = 1'b1;
         exp_q.push_back(c);
         c = base(ins); c.shift = ins[4:3]; c.aluop = op;
         if (op == 2'b01) c.loads = 1'b1;
         else             c.loadc = 1'b1;
         exp_q.push_back(c);
         if (op != 2'b01) begin
            c = base(ins); c.writenum = ins[7:5]; c.write = 1'b1;
            exp_q.push_back(c);
         end
      end else begin                                  // illegal
         c = base(ins); c.illegal = 1'b1;
         exp_q.push_back(c);
      end
   endtask

   function automatic bit is_legal(input logic [15:0] r);
      return (r[15:13] == 3'b101) ||
             (r[15:13] == 3'b110 && (r[12:11] == 2'b10 || r[12:11] == 2'b00));
   endfunction

   function automatic logic [15:0] rand_instr();
      logic [15:0] r;
      r = 16'($urandom);
      case ($urandom_range(0, 3))
         0: r[15:11] = 5'b110_10;
         1: r[15:11] = 5'b110_00;
         2: r[15:13] = 3'b101;
         default: begin
            for (int k = 0; k < 50 && is_legal(r); k++) r = 16'($urandom);
            if (is_legal(r)) r = 16'hE000;
         end
      endcase
      return r;
   endfunction

   // Driver tasks (all entered and left at a negedge with the DUT in WAIT)
   task automatic check_next(input string tag);
      if (exp_q.size() == 0) begin
         check({tag, "_underflow"}, 64'(obs_c), 64'h1_0000_0000_0);
      end else begin
         check(tag, 64'(obs_c), 64'(exp_q.pop_front()));
      end
   endtask

   task automatic idle_cycle(input string tag);
      exp_q.push_back(idle_vec(last_instr));
      check_next(tag);
      s  = 1'b0;
      in = 16'($urandom);
      @(negedge clk);
   endtask

   task automatic run_instr(input logic [15:0] ins, input string tag);
      int n;
      exp_q.push_back(idle_vec(last_instr));
      check_next({tag, "_wait"});
      model(ins);
      in = ins;
      s  = 1'b1;
      last_instr = ins;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_next($sformatf("%s_busy%0d", tag, i));
         // Busy states must ignore both s and in.
         s  = 1'($urandom_range(0, 1));
         in = 16'($urandom);
      end
      @(negedge clk);
      s = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      s     = 1'b0;
      in    = 16'h0000;
      last_instr = 16'h0000;

      @(negedge clk);
      exp_q.push_back(idle_vec(16'h0000));
      check_next("reset_c1");
      @(negedge clk);
      exp_q.push_back(idle_vec(16'h0000));
      check_next("reset_c2");
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) idle_cycle("idle_after_reset");

      // Directed instructions from the test plan
      run_instr(16'hD0F6, "mov_imm");
      run_instr(16'hA0A1, "add");
      run_instr(16'hA902, "cmp");
      run_instr(16'hB8E3, "mvn");
      run_instr(16'hC0B9, "mov_reg");
      run_instr(16'hE000, "illegal");
      idle_cycle("idle_post_illegal");

      // Reset asserted during GET_B of an ADD
      exp_q.push_back(idle_vec(last_instr));
      check_next("rst_mid_wait");
      model(16'hA0A1);
      in = 16'hA0A1;
      s  = 1'b1;
      @(negedge clk);
      check_next("rst_mid_decode");
      s = 1'b0;
      @(negedge clk);
      check_next("rst_mid_get_a");
      @(negedge clk);
      check_next("rst_mid_get_b");
      reset = 1'b1;
      exp_q.delete();
      last_instr = 16'h0000;
      @(negedge clk);
      exp_q.push_back(idle_vec(16'h0000));
      check_next("rst_mid_after");
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) idle_cycle("rst_mid_idle");

      // Randomized instruction stream
      for (int t = 0; t < 60; t++) begin
         int gap;
         run_instr(rand_instr(), $sformatf("rnd%0d", t));
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) idle_cycle($sformatf("rnd%0d_gap", t));
      end
      idle_cycle("final_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
